// File: rtl/game_pkg.sv
// Shared types and constants for the game pacing and ADC scheduling logic.
package game_pkg;

  localparam int DATA_W_DEFAULT = 12;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    REQ_P1,
    REQ_P2,
    STEP
  } sched_state_t;

  localparam logic CH_P1       = 1'b0;
  localparam logic CH_P2       = 1'b1;
  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_MULTI  = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Free-running period counter: one-cycle tick every TICK_CYCLES clocks while en is high.
// Held at zero when disabled, so the first tick lands TICK_CYCLES cycles after en rises.
module tick_gen #(
  parameter int TICK_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/adc_round_sched.sv
// Shares the board ADC between P1/P2 once per game tick and emits a step strobe per good round.
// step follows the last adc_valid by one cycle; adc_req is held until adc_valid or timeout.
module adc_round_sched
  import game_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int TICK_CYCLES    = 100000,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  output logic              adc_req,
  output logic              adc_ch,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] p1data,
  output logic [DATA_W-1:0] p2data,
  output logic              step,
  output logic              running,
  output logic              err_timeout,
  output logic              err_overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  sched_state_t  state, state_nxt;
  logic          tick;
  logic          mode_r;
  logic          stop_pending;
  logic [TW-1:0] to_cnt;
  logic          in_req;
  logic          to_expire;
  logic          stop_now;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (running),
    .tick (tick)
  );

  assign in_req    = (state == REQ_P1) || (state == REQ_P2);
  // A valid arriving on the last allowed cycle still counts as a good sample.
  assign to_expire = in_req && !adc_valid && (to_cnt == TO_LAST);
  assign stop_now  = stop_pending || stop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (stop)      state_nxt = IDLE;
        else if (tick) state_nxt = REQ_P1;
      end
      REQ_P1: begin
        if (adc_valid)      state_nxt = (mode_r == MODE_MULTI) ? REQ_P2 : STEP;
        else if (to_expire) state_nxt = stop_now ? IDLE : WAIT_TICK;
      end
      REQ_P2: begin
        if (adc_valid)      state_nxt = STEP;
        else if (to_expire) state_nxt = stop_now ? IDLE : WAIT_TICK;
      end
      STEP: begin
        state_nxt = stop_now ? IDLE : WAIT_TICK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    adc_req = 1'b0;
    adc_ch  = CH_P1;
    step    = 1'b0;
    running = (state != IDLE);
    case (state)
      REQ_P1: begin
        adc_req = 1'b1;
        adc_ch  = CH_P1;
      end
      REQ_P2: begin
        adc_req = 1'b1;
        adc_ch  = CH_P2;
      end
      STEP:    step = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_r       <= MODE_SINGLE;
      stop_pending <= 1'b0;
      p1data       <= '0;
      p2data       <= '0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
      to_cnt       <= '0;
    end else begin
      if (state == WAIT_TICK && state_nxt == REQ_P1) mode_r <= mode;

      if (state == IDLE)                           stop_pending <= 1'b0;
      else if (stop && (in_req || state == STEP)) stop_pending <= 1'b1;

      if (state == REQ_P1 && adc_valid) p1data <= adc_data;
      if (state == REQ_P2 && adc_valid) p2data <= adc_data;

      if (to_expire) err_timeout <= 1'b1;
      // Ticks that land mid-round are dropped; the free-running period keeps the schedule fixed.
      if (tick && state != WAIT_TICK) err_overrun <= 1'b1;

      to_cnt <= (in_req && state_nxt == state) ? to_cnt + TW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_adc_round_sched.sv
// Timeline bench: rounds are planned arithmetically, then replayed cycle by cycle against the DUT.
module tb_adc_round_sched;

  localparam int DW = 12;
  localparam int TK = 8;
  localparam int TO = 5;
  localparam int N  = 1400;

  logic          clk = 1'b0;
  logic          reset, mode, start, stop, adc_valid;
  logic [DW-1:0] adc_data;
  logic          adc_req, adc_ch, step, running, err_timeout, err_overrun;
  logic [DW-1:0] p1data, p2data;

  always #5 clk = ~clk;

  adc_round_sched #(
    .DATA_W(DW),
    .TICK_CYCLES(TK),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .stop(stop),
    .adc_req(adc_req), .adc_ch(adc_ch), .adc_valid(adc_valid), .adc_data(adc_data),
    .p1data(p1data), .p2data(p2data), .step(step), .running(running),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  // Per-cycle drive plan (value held during cycle c, sampled at the following edge).
  logic          drv_reset [N];
  logic          drv_mode  [N];
  logic          drv_start [N];
  logic          drv_stop  [N];
  logic          drv_valid [N];
  logic [DW-1:0] drv_data  [N];
  // Expected outputs in cycle c (after edge c).
  logic          exp_req [N];
  logic          exp_ch  [N];
  logic          exp_step[N];
  logic          exp_run [N];
  logic          exp_to  [N];
  logic          exp_ov  [N];
  logic [DW-1:0] exp_p1  [N];
  logic [DW-1:0] exp_p2  [N];
  // Events: value changes taking effect from cycle c onward.
  logic          ev_p1[N], ev_p2[N], ev_to[N], ev_ov[N], ev_on[N], ev_off[N], ev_rst[N];
  logic [DW-1:0] ev_p1_v[N], ev_p2_v[N];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, expv);
    end
  endtask

  // One round starting at edge e: P1 then optionally P2, each answered after lat cycles
  // (lat > TO means the ADC never answers). Returns the edge of the next round.
  task automatic add_round(input int e, input logic multi, input int lat1, input int lat2,
                           input logic [DW-1:0] d1, input logic [DW-1:0] d2, output int nxt);
    logic ok1, ok2, good;
    int   r1, r2, d;
    drv_mode[e-1] = multi;
    ok1 = (lat1 <= TO);
    r1  = ok1 ? lat1 : TO;
    for (int i = 0; i < r1; i++) begin
      exp_req[e+i] = 1'b1;
      exp_ch[e+i]  = 1'b0;
    end
    if (ok1) begin
      drv_valid[e+lat1-1] = 1'b1;
      drv_data[e+lat1-1]  = d1;
      ev_p1[e+lat1]       = 1'b1;
      ev_p1_v[e+lat1]     = d1;
    end else begin
      ev_to[e+TO] = 1'b1;
    end
    r2  = 0;
    ok2 = 1'b1;
    if (multi && ok1) begin
      ok2 = (lat2 <= TO);
      r2  = ok2 ? lat2 : TO;
      for (int i = 0; i < r2; i++) begin
        exp_req[e+r1+i] = 1'b1;
        exp_ch[e+r1+i]  = 1'b1;
      end
      if (ok2) begin
        drv_valid[e+r1+lat2-1] = 1'b1;
        drv_data[e+r1+lat2-1]  = d2;
        ev_p2[e+r1+lat2]       = 1'b1;
        ev_p2_v[e+r1+lat2]     = d2;
      end else begin
        ev_to[e+r1+TO] = 1'b1;
      end
    end
    good = ok1 && ok2;
    if (good) exp_step[e+r1+r2] = 1'b1;
    d = r1 + r2 + (good ? 1 : 0);
    if (d >= TK) ev_ov[e+TK] = 1'b1;
    nxt = e + (d / TK + 1) * TK;
  endtask

  initial begin
    int s, e, e2, x, off, last;
    logic [DW-1:0] p1, p2;
    logic to, ov, run;

    for (int c = 0; c < N; c++) begin
      drv_reset[c] = 1'b1; drv_mode[c] = 1'($urandom % 2); drv_start[c] = 1'b0;
      drv_stop[c]  = 1'b0; drv_valid[c] = 1'b0; drv_data[c] = '0;
      exp_req[c] = 1'b0; exp_ch[c] = 1'b0; exp_step[c] = 1'b0;
      ev_p1[c] = 1'b0; ev_p2[c] = 1'b0; ev_to[c] = 1'b0; ev_ov[c] = 1'b0;
      ev_on[c] = 1'b0; ev_off[c] = 1'b0; ev_rst[c] = 1'b0;
      ev_p1_v[c] = '0; ev_p2_v[c] = '0;
    end
    for (int c = 0; c < 4; c++) drv_reset[c] = 1'b0;
    drv_stop[6]  = 1'b1;
    drv_start[9] = 1'b1;
    s = 10;
    ev_on[s] = 1'b1;
    e = s + TK;

    add_round(e, 1'b0, 3, 0, 12'hA00, 12'h000, e);
    add_round(e, 1'b1, 3, 3, 12'h300, 12'h100, e);
    add_round(e, 1'b0, 99, 0, 12'h7FF, 12'h000, e);
    add_round(e, 1'b0, 2, 0, 12'h123, 12'h000, e);
    add_round(e, 1'b0, TO, 0, 12'h5A5, 12'h000, e);
    add_round(e, 1'b1, 3, 99, 12'h0F0, 12'hEEE, e);
    add_round(e, 1'b1, 4, 4, 12'h444, 12'h888, e);
    for (int i = 0; i < 30; i++)
      add_round(e, 1'($urandom % 2), 1 + int'($urandom % 7), 1 + int'($urandom % 7),
                DW'($urandom), DW'($urandom), e);

    // Stop lands inside REQ_P2: round completes with a step, then back to IDLE.
    x = e;
    add_round(x, 1'b1, 3, 3, 12'hABC, 12'hDEF, e);
    drv_stop[x+4] = 1'b1;
    off = x + 7;
    ev_off[off] = 1'b1;

    for (int c = s; c < off; c++)
      if ($urandom % 16 == 0) drv_start[c] = 1'b1;

    // Restart, then reset while P1 request is outstanding.
    x  = off + 3 * TK;
    drv_start[x] = 1'b1;
    ev_on[x+1]   = 1'b1;
    e2 = x + 1 + TK;
    exp_req[e2]   = 1'b1;
    exp_req[e2+1] = 1'b1;
    for (int c = e2 + 1; c < N; c++) drv_reset[c] = 1'b0;
    ev_rst[e2+2] = 1'b1;
    last = e2 + 8;
    if (last >= N) begin
      $display("FAIL plan_length last=%0d limit=%0d", last, N);
      $fatal(1, "plan overflow");
    end

    for (int c = 0; c < N; c++)
      if (!exp_req[c] && !drv_valid[c] && ($urandom % 4 == 0)) begin
        drv_valid[c] = 1'b1;
        drv_data[c]  = DW'($urandom);
      end

    p1 = '0; p2 = '0; to = 1'b0; ov = 1'b0; run = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (ev_p1[c])  p1  = ev_p1_v[c];
      if (ev_p2[c])  p2  = ev_p2_v[c];
      if (ev_to[c])  to  = 1'b1;
      if (ev_ov[c])  ov  = 1'b1;
      if (ev_on[c])  run = 1'b1;
      if (ev_off[c]) run = 1'b0;
      if (ev_rst[c]) begin
        p1 = '0; p2 = '0; to = 1'b0; ov = 1'b0; run = 1'b0;
      end
      exp_p1[c] = p1; exp_p2[c] = p2; exp_to[c] = to; exp_ov[c] = ov; exp_run[c] = run;
    end

    reset = 1'b0; mode = 1'b0; start = 1'b0; stop = 1'b0; adc_valid = 1'b0; adc_data = '0;

    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #1;
      chk("adc_req", c, 32'(adc_req), 32'(exp_req[c]));
      if (exp_req[c]) chk("adc_ch", c, 32'(adc_ch), 32'(exp_ch[c]));
      chk("step", c, 32'(step), 32'(exp_step[c]));
      chk("running", c, 32'(running), 32'(exp_run[c]));
      chk("p1data", c, 32'(p1data), 32'(exp_p1[c]));
      chk("p2data", c, 32'(p2data), 32'(exp_p2[c]));
      chk("err_timeout", c, 32'(err_timeout), 32'(exp_to[c]));
      chk("err_overrun", c, 32'(err_overrun), 32'(exp_ov[c]));
      reset     = drv_reset[c];
      mode      = drv_mode[c];
      start     = drv_start[c];
      stop      = drv_stop[c];
      adc_valid = drv_valid[c];
      adc_data  = drv_data[c];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
